// File: rtl/vc_dest_arbiter_pkg.sv
// Shared encodings and defaults for the VC-to-destination arbiter.
package vc_dest_arbiter_pkg;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int DEST_BIT_DEF   = 4;
    localparam int THR_WIDTH_DEF  = 4;
    localparam int CNT_WIDTH      = 8;

endpackage

// File: rtl/vc_dest_arbiter_route_stage.sv
// Tags the popped VC, then demuxes the returned word to D0/D1 by its dest bit.
// Push appears two cycles after the pop; no stall path, in-flight words always land.
module vc_dest_arbiter_route_stage
    import vc_dest_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEST_BIT   = DEST_BIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  vc0_pop,
    input  logic                  vc1_pop,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [DATA_WIDTH-1:0] d0_data,
    output logic [DATA_WIDTH-1:0] d1_data,
    output logic                  busy
);

    logic                  sel;
    logic [DATA_WIDTH-1:0] word;
    logic                  to_d1;

    // busy marks that the VC read data arriving this cycle belongs to us
    assign word  = sel ? vc1_data : vc0_data;
    assign to_d1 = word[DEST_BIT];

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            busy    <= 1'b0;
            sel     <= 1'b0;
            d0_push <= 1'b0;
            d1_push <= 1'b0;
            d0_data <= '0;
            d1_data <= '0;
        end else begin
            busy    <= vc0_pop | vc1_pop;
            sel     <= vc1_pop;
            d0_push <= busy & ~to_d1;
            d1_push <= busy & to_d1;
            if (busy && !to_d1) d0_data <= word;
            if (busy && to_d1)  d1_data <= word;
        end
    end

endmodule

// File: rtl/vc_dest_arbiter.sv
// Strict-priority VC0/VC1 pop arbiter with threshold distribution and push counter.
// Pop-to-push latency 2 cycles; pops stall on either destination almost_full or init.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEST_BIT   = DEST_BIT_DEF,
    parameter int THR_WIDTH  = THR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [THR_WIDTH-1:0]  umb_af_in,
    input  logic [THR_WIDTH-1:0]  umb_ae_in,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [DATA_WIDTH-1:0] d0_data,
    output logic [DATA_WIDTH-1:0] d1_data,
    output logic [THR_WIDTH-1:0]  umb_af,
    output logic [THR_WIDTH-1:0]  umb_ae,
    output logic [3:0]            state,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  fwd_count
);

    logic [3:0] state_nxt;
    logic       stage_busy;
    logic       inflight;
    logic       pop_ok;

    assign inflight = vc0_pop | vc1_pop | stage_busy;
    // destination is unknown until data returns, so either almost_full blocks
    assign pop_ok   = (state == ST_ACTIVE) && !init && !d0_almost_full && !d1_almost_full;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   state_nxt = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init)                         state_nxt = ST_INIT;
                else if (!vc0_empty || !vc1_empty) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                      state_nxt = ST_INIT;
                else if (vc0_empty && vc1_empty && !inflight)  state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            state     <= ST_RESET;
            vc0_pop   <= 1'b0;
            vc1_pop   <= 1'b0;
            umb_af    <= '0;
            umb_ae    <= '0;
            idle      <= 1'b0;
            fwd_count <= '0;
        end else begin
            state   <= state_nxt;
            vc0_pop <= pop_ok & ~vc0_empty;
            vc1_pop <= pop_ok & vc0_empty & ~vc1_empty;
            if (state == ST_INIT) begin
                umb_af <= umb_af_in;
                umb_ae <= umb_ae_in;
            end
            idle <= (state == ST_IDLE) && (state_nxt == ST_IDLE) && !inflight;
            if (d0_push || d1_push) fwd_count <= fwd_count + CNT_WIDTH'(1);
        end
    end

    vc_dest_arbiter_route_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEST_BIT   (DEST_BIT)
    ) u_route_stage (
        .clk      (clk),
        .reset_L  (reset_L),
        .vc0_pop  (vc0_pop),
        .vc1_pop  (vc1_pop),
        .vc0_data (vc0_data),
        .vc1_data (vc1_data),
        .d0_push  (d0_push),
        .d1_push  (d1_push),
        .d0_data  (d0_data),
        .d1_data  (d1_data),
        .busy     (stage_busy)
    );

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Bench: queue-backed VC FIFO models feeding the arbiter, with a pop/push scoreboard.
module tb_vc_dest_arbiter;

    localparam int DW = 6;
    localparam int DB = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic [TW-1:0] umb_af_in, umb_ae_in;
    logic          vc0_empty, vc1_empty;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          d0_almost_full, d1_almost_full;
    logic          vc0_pop, vc1_pop, d0_push, d1_push;
    logic [DW-1:0] d0_data, d1_data;
    logic [TW-1:0] umb_af, umb_ae;
    logic [3:0]    state;
    logic          idle;
    logic [7:0]    fwd_count;

    vc_dest_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DB), .THR_WIDTH(TW)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umb_af_in(umb_af_in), .umb_ae_in(umb_ae_in),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_push(d0_push), .d1_push(d1_push),
        .d0_data(d0_data), .d1_data(d1_data),
        .umb_af(umb_af), .umb_ae(umb_ae),
        .state(state), .idle(idle), .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q0[$], q1[$];
    logic [DW-1:0] exp_w[$];
    int            exp_c[$];
    logic [DW-1:0] pend0, pend1;
    logic          pend0_v, pend1_v;
    int cyc, n_chk, n_fail, exp_cnt, push_total, pop0_n, pop1_n, push0_n, push1_n;
    int last_p0, first_p1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void upd_empty();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
    endfunction

    function automatic void add_word(input int vc, input logic [DW-1:0] w);
        if (vc == 0) q0.push_back(w); else q1.push_back(w);
        upd_empty();
    endfunction

    // Checks the cycle just launched by the last rising edge; inputs still hold the
    // values sampled at that edge.
    task automatic monitor();
        logic [DW-1:0] w;
        int c;
        chk("pop_excl", {31'd0, vc0_pop & vc1_pop}, 0);
        chk("push_excl", {31'd0, d0_push & d1_push}, 0);
        if (vc0_pop || vc1_pop)
            chk("pop_perm", {29'd0, init, d0_almost_full, d1_almost_full}, 0);
        if (d0_push || d1_push) begin
            if (exp_w.size() == 0) chk("push_unexpected", 1, 0);
            else begin
                w = exp_w.pop_front();
                c = exp_c.pop_front();
                chk("push_lat", cyc, c + 2);
                chk("push_dest", {31'd0, d1_push}, {31'd0, w[DB]});
                chk("push_data", d1_push ? d1_data : d0_data, w);
                exp_cnt = (exp_cnt + 1) % 256;
                push_total++;
                if (d0_push) push0_n++; else push1_n++;
            end
        end
        if (vc0_pop) begin
            chk("pop0_flag", {31'd0, vc0_empty}, 0);
            pop0_n++; last_p0 = cyc;
            if (q0.size() > 0) begin
                pend0 = q0.pop_front(); pend0_v = 1'b1;
                exp_w.push_back(pend0); exp_c.push_back(cyc);
            end
        end
        if (vc1_pop) begin
            chk("pop1_prio", {31'd0, vc0_empty}, 1);
            chk("pop1_flag", {31'd0, vc1_empty}, 0);
            pop1_n++;
            if (first_p1 < 0) first_p1 = cyc;
            if (q1.size() > 0) begin
                pend1 = q1.pop_front(); pend1_v = 1'b1;
                exp_w.push_back(pend1); exp_c.push_back(cyc);
            end
        end
        upd_empty();
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (pend0_v) begin vc0_data = pend0; pend0_v = 1'b0; end
        if (pend1_v) begin vc1_data = pend1; pend1_v = 1'b0; end
        @(negedge clk);
        monitor();
    endtask

    task automatic drain(input int max);
        int i;
        i = 0;
        while ((q0.size() + q1.size() + exp_w.size()) != 0 && i < max) begin
            tick();
            i++;
        end
        chk("drain_timeout", {31'd0, i < max}, 1);
        repeat (3) tick();
    endtask

    task automatic wait_pop0();
        for (int i = 0; i < 10 && !vc0_pop; i++) tick();
        chk("pop_start", {31'd0, vc0_pop}, 1);
        tick();
    endtask

    initial begin
        int pb;
        n_chk = 0; n_fail = 0; cyc = 0; exp_cnt = 0; push_total = 0;
        pop0_n = 0; pop1_n = 0; push0_n = 0; push1_n = 0; last_p0 = -1; first_p1 = -1;
        pend0_v = 0; pend1_v = 0; pend0 = '0; pend1 = '0;
        reset_L = 1'b1; init = 1'b0; umb_af_in = '0; umb_ae_in = '0;
        vc0_data = '0; vc1_data = '0; d0_almost_full = 0; d1_almost_full = 0;
        upd_empty();

        // reset and init
        repeat (2) tick();
        chk("rst_state", state, 4'b0001);
        chk("rst_out", {vc0_pop, vc1_pop, d0_push, d1_push, idle, d0_data, d1_data, umb_af, umb_ae, fwd_count}, 0);
        reset_L = 1'b0; init = 1'b1; umb_af_in = 4'd6; umb_ae_in = 4'd1;
        tick();
        chk("state_init", state, 4'b0010);
        repeat (2) tick();
        init = 1'b0;
        tick();
        chk("state_idle", state, 4'b0100);
        chk("umb_af", umb_af, 6);
        chk("umb_ae", umb_ae, 1);
        chk("strobes_idle", {vc0_pop, vc1_pop, d0_push, d1_push}, 0);

        // directed three-word VC0 stream
        pop0_n = 0; pop1_n = 0; push0_n = 0; push1_n = 0;
        add_word(0, 6'h01); add_word(0, 6'h12); add_word(0, 6'h05);
        drain(50);
        chk("dir_pop0", pop0_n, 3);
        chk("dir_pop1", pop1_n, 0);
        chk("dir_d0", push0_n, 2);
        chk("dir_d1", push1_n, 1);
        chk("dir_count", fwd_count, 3);
        chk("dir_idle", {31'd0, idle}, 1);
        chk("dir_state", state, 4'b0100);

        // both VCs loaded: all VC0 before any VC1
        pop0_n = 0; pop1_n = 0; last_p0 = -1; first_p1 = -1;
        for (int i = 0; i < 5; i++) begin
            add_word(0, DW'($urandom_range(0, 63)));
            add_word(1, DW'($urandom_range(0, 63)));
        end
        drain(80);
        chk("prio_pop0", pop0_n, 5);
        chk("prio_pop1", pop1_n, 5);
        chk("prio_order", {31'd0, first_p1 > last_p0}, 1);
        chk("prio_count", fwd_count, exp_cnt);

        // destination backpressure mid-stream
        for (int i = 0; i < 10; i++) add_word(0, DW'($urandom_range(0, 63)));
        wait_pop0();
        d1_almost_full = 1'b1;
        pb = push_total;
        tick();
        chk("af_stop", {31'd0, vc0_pop}, 0);
        repeat (3) tick();
        chk("af_inflight", push_total - pb, 2);
        d1_almost_full = 1'b0;
        tick();
        chk("af_resume", {31'd0, vc0_pop}, 1);
        drain(80);
        chk("af_count", fwd_count, exp_cnt);

        // init while ACTIVE with two words in flight
        for (int i = 0; i < 8; i++) add_word(0, DW'($urandom_range(0, 63)));
        wait_pop0();
        init = 1'b1; umb_af_in = 4'd9; umb_ae_in = 4'd2;
        pb = push_total;
        tick();
        chk("init_nopop", {31'd0, vc0_pop | vc1_pop}, 0);
        chk("init_state", state, 4'b0010);
        repeat (3) tick();
        chk("init_inflight", push_total - pb, 2);
        chk("init_sb_empty", exp_w.size(), 0);
        chk("init_umb_af", umb_af, 9);
        chk("init_umb_ae", umb_ae, 2);
        init = 1'b0;
        drain(80);
        umb_af_in = 4'd3; umb_ae_in = 4'd7;
        repeat (2) tick();
        chk("umb_hold", {umb_af, umb_ae}, {4'd9, 4'd2});

        // randomized traffic with random backpressure
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) add_word($urandom_range(0, 1), DW'($urandom_range(0, 63)));
            d0_almost_full = ($urandom_range(0, 4) == 0);
            d1_almost_full = ($urandom_range(0, 4) == 0);
            tick();
        end
        d0_almost_full = 0; d1_almost_full = 0;
        drain(200);
        chk("rand_count", fwd_count, exp_cnt);
        chk("rand_idle", {31'd0, idle}, 1);

        // reset pulse with a word in flight
        for (int i = 0; i < 4; i++) add_word(0, DW'($urandom_range(0, 63)));
        wait_pop0();
        reset_L = 1'b1;
        #1;
        chk("arst_state", state, 4'b0001);
        chk("arst_out", {vc0_pop, vc1_pop, d0_push, d1_push, idle, d0_data, d1_data, umb_af, umb_ae, fwd_count}, 0);
        q0.delete(); q1.delete(); exp_w.delete(); exp_c.delete();
        pend0_v = 0; pend1_v = 0; exp_cnt = 0; push_total = 0;
        upd_empty();
        repeat (2) tick();
        chk("arst_nopush", {d0_push, d1_push}, 0);
        reset_L = 1'b0; init = 1'b1;
        repeat (2) tick();
        init = 1'b0;
        tick();
        chk("arst_idle", state, 4'b0100);
        chk("arst_umb", {umb_af, umb_ae}, {4'd3, 4'd7});
        chk("arst_count", fwd_count, 0);

        // counter wrap: 260 words
        for (int i = 0; i < 260; i++) add_word($urandom_range(0, 1), DW'($urandom_range(0, 63)));
        drain(1000);
        chk("wrap_total", push_total, 260);
        chk("wrap_count", fwd_count, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_dest_arbiter.md
# vc_dest_arbiter

Arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the switch datapath. Pops words from the VCs with strict VC0 priority and routes each word to D0 or D1 by its destination bit. It also holds flow control against destination almost_full and distributes the almost_full/almost_empty thresholds loaded during an init phase. One instance per switch; all four FIFOs are stock FIFO instances.

## Interface
Parameters:
- DATA_WIDTH, 6, width of a FIFO word
- DEST_BIT, 4, bit index of the word that selects the destination (0 = D0, 1 = D1)
- THR_WIDTH, 4, width of threshold values

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_L  in  1  reset, asynchronous, active-high
- init  in  1  while high, forces INIT and loads thresholds
- umb_af_in, umb_ae_in  in  THR_WIDTH  threshold values captured in INIT
- vc0_empty, vc1_empty  in  1  VC FIFO empty flags
- vc0_data, vc1_data  in  DATA_WIDTH  VC FIFO read data; valid the cycle after the pop
- d0_almost_full, d1_almost_full  in  1  destination backpressure
- vc0_pop, vc1_pop  out  1  read strobes to the VC FIFOs (registered)
- d0_push, d1_push  out  1  write strobes to the destination FIFOs (registered)
- d0_data, d1_data  out  DATA_WIDTH  write data to the destinations (registered)
- umb_af, umb_ae  out  THR_WIDTH  thresholds driven to all four FIFOs
- state  out  4  one-hot state
- idle  out  1  high in IDLE with the pipeline empty
- fwd_count  out  8  total words pushed; wraps 255 -> 0

## Operation
- States, one-hot: RESET = 4'b0001, INIT = 4'b0010, IDLE = 4'b0100, ACTIVE = 4'b1000.
- RESET -> INIT on the first clk edge after reset_L falls.
- INIT:
  - umb_af <= umb_af_in and umb_ae <= umb_ae_in on every cycle.
  - Goes to IDLE on the first edge with init = 0.
- IDLE:
  - init = 1 -> INIT.
  - Otherwise any VC non-empty -> ACTIVE.
- ACTIVE:
  - init = 1 -> INIT. No new pops from that edge on; words already in flight complete their pushes.
  - Both VCs empty and no word in flight -> IDLE.
- Pop permission: state ACTIVE, init = 0, d0_almost_full = 0 and d1_almost_full = 0. Both destinations are checked because the destination is unknown until the data returns.
- Priority: if permitted, pop VC0 when vc0_empty = 0. Otherwise pop VC1 when vc1_empty = 0. vc0_pop and vc1_pop are never both high.
- Routing: the returned word goes to D0 if word[DEST_BIT] = 0, else to D1. d0_push and d1_push are never both high. The data on the inactive destination port holds its last value.
- fwd_count increments by 1 per push cycle; 8-bit wrap.

## Timing
- Reset values: state = RESET; every pop, push, data, umb_*, idle and fwd_count output = 0. In-flight words are discarded on reset with no push.
- Pipeline, for a pop high during cycle k:
  - VC data is valid in cycle k+1 and captured at the end of k+1.
  - dX_push and dX_data are high/valid in cycle k+2.
- Throughput: one word per cycle sustained. At most 2 words in flight.
- Backpressure: almost_full is sampled at the edge that would raise a pop. Up to 2 words already in flight still land, so destination thresholds must leave ≥2 free slots.
- A VC going empty during the same cycle as a pop is legal; the FIFO ignores reads when empty, and the arbiter must not pop a VC whose empty flag is high at the decision edge.
- idle is registered and rises one cycle after the IDLE entry conditions hold.

## Structure
- Shared package: state encodings, DATA_WIDTH / DEST_BIT / THR_WIDTH defaults, and the 8-bit count width.
- Sub-module route_stage: captures VC data and the selected-VC tag, then registers the push/data demux to D0/D1. The top level holds the FSM, pop logic, threshold registers and fwd_count.

## Test plan
- Reset, then init = 1 for 3 cycles with umb_af_in = 4'd6 and umb_ae_in = 4'd1, then init = 0 -> state goes RESET, INIT, IDLE; umb_af = 6 and umb_ae = 1; all strobes 0.
- VC0 holds 3 words 6'h01, 6'h12, 6'h05, VC1 empty -> vc0_pop high for 3 cycles; pushes arrive 2 cycles later in the order D0 6'h01, D1 6'h12, D0 6'h05; fwd_count = 3; then IDLE with idle = 1.
- Both VCs non-empty -> only vc0_pop until vc0_empty is seen, then vc1_pop; never both high in one cycle.
- d1_almost_full raised mid-stream -> pops stop at that edge; exactly the ≤2 in-flight words are pushed; pops resume the cycle after the flag drops.
- init raised in ACTIVE with 2 words in flight -> both words are pushed, no further pops, state = INIT; reset_L pulsed with a word in flight -> no push and all outputs 0.
- 260 words forwarded -> fwd_count wraps and reads 4.
